// File: rtl/bus_cycle_unit.sv
// Purpose: 8085 machine-cycle engine (T1,T2,Tw,T3) driving the muxed AD bus, strobes and status, with READY waits and HOLD/HLDA.
// Latency: req_ack to done is 4 phi1 cycles with zero wait states (T1,T2,T3, then done); each Tw adds one cycle.
// Backpressure: READY stretches T2 into Tw (bounded by WAIT_LIMIT); HOLD or a cycle in flight keeps req_ack low, so the sequencer holds req.
module bus_cycle_unit #(
    parameter int WAIT_LIMIT = 16,
    parameter int WCNT_W     = 5
) (
    input  logic        phi1,
    input  logic        reset,
    input  logic        req,
    input  logic [2:0]  cyc_type,
    input  logic [15:0] addr,
    input  logic [7:0]  wdata,
    output logic        req_ack,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic [7:0]  rdata,
    output logic [7:0]  next_instruction,
    input  logic [7:0]  ad_in,
    output logic [7:0]  ad_out,
    output logic        ad_oe,
    output logic [7:0]  a_hi,
    output logic        bus_oe,
    output logic        ALE,
    output logic        RDn,
    output logic        WRn,
    output logic        INTAn,
    output logic        IOMn,
    output logic        S1,
    output logic        S0,
    input  logic        READY,
    input  logic        HOLD,
    output logic        HLDA
);

    typedef enum logic [2:0] {S_IDLE, S_T1, S_T2, S_TW, S_T3, S_THOLD} state_t;

    localparam logic [2:0] CT_FETCH = 3'd0;
    localparam logic [2:0] CT_MRD   = 3'd1;
    localparam logic [2:0] CT_MWR   = 3'd2;
    localparam logic [2:0] CT_IORD  = 3'd3;
    localparam logic [2:0] CT_IOWR  = 3'd4;
    localparam logic [2:0] CT_INTA  = 3'd5;

    localparam logic [WCNT_W-1:0] WLIM = WCNT_W'(WAIT_LIMIT);

    // {IOMn,S1,S0} for each machine-cycle type
    function automatic logic [2:0] status_of(input logic [2:0] t);
        logic [2:0] s;
        case (t)
            CT_FETCH: s = 3'b011;
            CT_MRD:   s = 3'b010;
            CT_MWR:   s = 3'b001;
            CT_IORD:  s = 3'b110;
            CT_IOWR:  s = 3'b101;
            CT_INTA:  s = 3'b111;
            default:  s = 3'b000;
        endcase
        return s;
    endfunction

    state_t            state, state_n;
    logic [2:0]        cur_type, cur_type_n;
    logic [7:0]        cur_wdata, cur_wdata_n;
    logic [WCNT_W-1:0] wcnt, wcnt_n;
    logic              to_pend, to_pend_n;
    logic [2:0]        stat_q, stat_n;
    logic              ale_n, rdn_n, wrn_n, intan_n, ad_oe_n, bus_oe_n, hlda_n;
    logic              done_n, timeout_n;
    logic [7:0]        ad_out_n, a_hi_n, rdata_n, ni_n;
    logic              valid_req, cur_is_write, accept, go_hold;

    assign valid_req    = req && (cyc_type <= CT_INTA);
    assign cur_is_write = (cur_type == CT_MWR) || (cur_type == CT_IOWR);
    assign busy         = (state != S_IDLE);
    assign req_ack      = accept;
    assign {IOMn, S1, S0} = stat_q;

    // State and all registered bus outputs; reset forces the idle bus picture immediately
    always_ff @(posedge phi1 or posedge reset) begin
        if (reset) begin
            state            <= S_IDLE;
            cur_type         <= 3'd0;
            cur_wdata        <= 8'h00;
            wcnt             <= '0;
            to_pend          <= 1'b0;
            stat_q           <= 3'b000;
            ALE              <= 1'b0;
            RDn              <= 1'b1;
            WRn              <= 1'b1;
            INTAn            <= 1'b1;
            ad_oe            <= 1'b0;
            bus_oe           <= 1'b1;
            HLDA             <= 1'b0;
            done             <= 1'b0;
            timeout          <= 1'b0;
            ad_out           <= 8'h00;
            a_hi             <= 8'h00;
            rdata            <= 8'h00;
            next_instruction <= 8'h00;
        end else begin
            state            <= state_n;
            cur_type         <= cur_type_n;
            cur_wdata        <= cur_wdata_n;
            wcnt             <= wcnt_n;
            to_pend          <= to_pend_n;
            stat_q           <= stat_n;
            ALE              <= ale_n;
            RDn              <= rdn_n;
            WRn              <= wrn_n;
            INTAn            <= intan_n;
            ad_oe            <= ad_oe_n;
            bus_oe           <= bus_oe_n;
            HLDA             <= hlda_n;
            done             <= done_n;
            timeout          <= timeout_n;
            ad_out           <= ad_out_n;
            a_hi             <= a_hi_n;
            rdata            <= rdata_n;
            next_instruction <= ni_n;
        end
    end

    // Next state plus the output values for the state being entered
    always_comb begin
        state_n     = state;
        cur_type_n  = cur_type;
        cur_wdata_n = cur_wdata;
        wcnt_n      = wcnt;
        to_pend_n   = to_pend;
        stat_n      = stat_q;
        ale_n       = ALE;
        rdn_n       = RDn;
        wrn_n       = WRn;
        intan_n     = INTAn;
        ad_oe_n     = ad_oe;
        bus_oe_n    = bus_oe;
        hlda_n      = HLDA;
        done_n      = 1'b0;
        timeout_n   = timeout;
        ad_out_n    = ad_out;
        a_hi_n      = a_hi;
        rdata_n     = rdata;
        ni_n        = next_instruction;
        accept      = 1'b0;
        go_hold     = 1'b0;

        case (state)
            S_IDLE: begin
                if (HOLD)           go_hold = 1'b1;
                else if (valid_req) accept  = 1'b1;
            end
            S_T1: begin
                state_n = S_T2;
                ale_n   = 1'b0;
                if (cur_is_write) begin
                    ad_out_n = cur_wdata;
                    wrn_n    = 1'b0;
                end else if (cur_type == CT_INTA) begin
                    ad_oe_n  = 1'b0;
                    intan_n  = 1'b0;
                end else begin
                    ad_oe_n  = 1'b0;
                    rdn_n    = 1'b0;
                end
            end
            S_T2: begin
                if (!READY) begin
                    state_n = S_TW;
                    wcnt_n  = WCNT_W'(1);
                end else begin
                    state_n = S_T3;
                end
            end
            S_TW: begin
                if (READY) begin
                    state_n = S_T3;
                end else if ((WAIT_LIMIT != 0) && (wcnt == WLIM)) begin
                    // Device never answered: force the cycle closed and flag it on done
                    state_n   = S_T3;
                    to_pend_n = 1'b1;
                end else begin
                    wcnt_n = wcnt + 1'b1;
                end
            end
            S_T3: begin
                rdn_n     = 1'b1;
                wrn_n     = 1'b1;
                intan_n   = 1'b1;
                wcnt_n    = '0;
                done_n    = 1'b1;
                timeout_n = to_pend;
                to_pend_n = 1'b0;
                if (!cur_is_write)        rdata_n = ad_in;
                if (cur_type == CT_FETCH) ni_n    = ad_in;
                if (HOLD) begin
                    go_hold = 1'b1;
                end else if (valid_req) begin
                    accept = 1'b1;
                end else begin
                    state_n = S_IDLE;
                    stat_n  = 3'b000;
                    ad_oe_n = 1'b0;
                end
            end
            S_THOLD: begin
                if (!HOLD) begin
                    state_n  = S_IDLE;
                    hlda_n   = 1'b0;
                    bus_oe_n = 1'b1;
                end
            end
            default: state_n = S_IDLE;
        endcase

        // Bus released to the external master; a_hi keeps its last value
        if (go_hold) begin
            state_n  = S_THOLD;
            hlda_n   = 1'b1;
            ad_oe_n  = 1'b0;
            bus_oe_n = 1'b0;
            stat_n   = 3'b000;
            ale_n    = 1'b0;
            rdn_n    = 1'b1;
            wrn_n    = 1'b1;
            intan_n  = 1'b1;
        end

        // New cycle starts: address phase on AD, request fields captured
        if (accept) begin
            state_n     = S_T1;
            cur_type_n  = cyc_type;
            cur_wdata_n = wdata;
            ale_n       = 1'b1;
            ad_oe_n     = 1'b1;
            ad_out_n    = addr[7:0];
            a_hi_n      = addr[15:8];
            stat_n      = status_of(cyc_type);
            rdn_n       = 1'b1;
            wrn_n       = 1'b1;
            intan_n     = 1'b1;
        end
    end

endmodule

// File: tb/tb_bus_cycle_unit.sv
// Purpose: self-checking bench for bus_cycle_unit; random machine cycles against a transaction-level model.
// Latency: model expects T1, T2, min(waits,LIMIT) Tw, T3, then done; timeout when READY stays low past LIMIT waits.
// Backpressure: READY and HOLD are driven from per-transaction plans; req_ack is checked combinationally.
module tb_bus_cycle_unit;
    localparam int LIMIT = 4;

    logic        phi1 = 1'b0;
    logic        reset, req, READY, HOLD;
    logic [2:0]  cyc_type;
    logic [15:0] addr;
    logic [7:0]  wdata, ad_in;
    logic        req_ack, busy, done, timeout, ad_oe, bus_oe;
    logic        ALE, RDn, WRn, INTAn, IOMn, S1, S0, HLDA;
    logic [7:0]  rdata, next_instruction, ad_out, a_hi;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [7:0]  exp_rdata = 8'h00;
    logic [7:0]  exp_ni    = 8'h00;
    logic [7:0]  exp_ahi   = 8'h00;
    logic        exp_to    = 1'b0;
    logic [2:0]  stat_tab [0:5] = '{3'b011, 3'b010, 3'b001, 3'b110, 3'b101, 3'b111};

    bus_cycle_unit #(.WAIT_LIMIT(LIMIT), .WCNT_W(5)) dut (
        .phi1(phi1), .reset(reset), .req(req), .cyc_type(cyc_type), .addr(addr), .wdata(wdata),
        .req_ack(req_ack), .busy(busy), .done(done), .timeout(timeout), .rdata(rdata),
        .next_instruction(next_instruction), .ad_in(ad_in), .ad_out(ad_out), .ad_oe(ad_oe),
        .a_hi(a_hi), .bus_oe(bus_oe), .ALE(ALE), .RDn(RDn), .WRn(WRn), .INTAn(INTAn),
        .IOMn(IOMn), .S1(S1), .S0(S0), .READY(READY), .HOLD(HOLD), .HLDA(HLDA)
    );

    always #5 phi1 = ~phi1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick;
        @(posedge phi1);
        #1;
    endtask

    function automatic bit is_wr(input logic [2:0] ty);
        return (ty == 3'd2) || (ty == 3'd4);
    endfunction

    // {RDn,WRn,INTAn} while the data phase is active
    function automatic logic [2:0] strobe_low(input logic [2:0] ty);
        if (is_wr(ty))       return 3'b101;
        else if (ty == 3'd5) return 3'b110;
        else                 return 3'b011;
    endfunction

    task automatic issue(input logic [2:0] ty, input logic [15:0] ad, input logic [7:0] wd);
        cyc_type = ty;
        addr     = ad;
        wdata    = wd;
        req      = 1'b1;
        #1;
        check_eq("req_ack", req_ack, 1);
    endtask

    task automatic check_t1(input logic [2:0] ty, input logic [15:0] ad);
        check_eq("t1_ale", ALE, 1);
        check_eq("t1_ad_oe", ad_oe, 1);
        check_eq("t1_ad_out", ad_out, ad[7:0]);
        check_eq("t1_a_hi", a_hi, ad[15:8]);
        check_eq("t1_status", {IOMn, S1, S0}, stat_tab[ty]);
        check_eq("t1_strobes", {RDn, WRn, INTAn}, 3'b111);
        check_eq("t1_busy", busy, 1);
        exp_ahi = ad[15:8];
        req     = 1'b0;
    endtask

    // Data phase: k = number of READY-low samples starting at T2
    task automatic body(input logic [2:0] ty, input logic [7:0] wd, input int k, input logic [7:0] din,
                        input bit hold, input bit chain, input logic [2:0] cty,
                        input logic [15:0] cad, input logic [7:0] cwd);
        int len;
        len = 2 + ((k < LIMIT) ? k : LIMIT);
        tick;
        for (int i = 0; i < len; i++) begin
            check_eq("dp_strobes", {RDn, WRn, INTAn}, strobe_low(ty));
            check_eq("dp_ale", ALE, 0);
            check_eq("dp_status", {IOMn, S1, S0}, stat_tab[ty]);
            check_eq("dp_a_hi", a_hi, exp_ahi);
            check_eq("dp_ad_oe", ad_oe, is_wr(ty) ? 1 : 0);
            check_eq("dp_done", done, 0);
            if (is_wr(ty)) check_eq("dp_wdata", ad_out, wd);
            READY = (i >= k);
            ad_in = (i == len - 1) ? din : ~din;
            if (hold && i == 0) HOLD = 1'b1;
            if (chain && i == len - 1) issue(cty, cad, cwd);
            tick;
        end
        READY = 1'b1;
        if (!is_wr(ty)) exp_rdata = din;
        if (ty == 3'd0) exp_ni = din;
        exp_to = (k > LIMIT);
        check_eq("done", done, 1);
        check_eq("timeout", timeout, exp_to);
        check_eq("rdata", rdata, exp_rdata);
        check_eq("next_instr", next_instruction, exp_ni);
        check_eq("end_strobes", {RDn, WRn, INTAn}, 3'b111);
    endtask

    task automatic finish_cycle(input bit hold);
        if (hold) begin
            check_eq("hold_hlda", HLDA, 1);
            check_eq("hold_bus_oe", bus_oe, 0);
            check_eq("hold_ad_oe", ad_oe, 0);
            check_eq("hold_busy", busy, 1);
            HOLD = 1'b0;
            tick;
            check_eq("unhold_hlda", HLDA, 0);
            check_eq("unhold_bus_oe", bus_oe, 1);
        end else begin
            check_eq("idle_busy", busy, 0);
            check_eq("idle_ad_oe", ad_oe, 0);
            check_eq("idle_status", {IOMn, S1, S0}, 3'b000);
            check_eq("idle_a_hi", a_hi, exp_ahi);
            tick;
        end
        check_eq("post_done", done, 0);
        check_eq("post_timeout", timeout, exp_to);
        check_eq("post_busy", busy, 0);
    endtask

    task automatic full_txn(input logic [2:0] ty, input logic [15:0] ad, input logic [7:0] wd,
                            input int k, input logic [7:0] din, input bit hold);
        issue(ty, ad, wd);
        tick;
        check_t1(ty, ad);
        body(ty, wd, k, din, hold, 1'b0, 3'd0, 16'h0, 8'h0);
        finish_cycle(hold);
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_ale"}, ALE, 0);
        check_eq({tag, "_strobes"}, {RDn, WRn, INTAn}, 3'b111);
        check_eq({tag, "_status"}, {IOMn, S1, S0}, 3'b000);
        check_eq({tag, "_oe"}, {ad_oe, bus_oe, HLDA}, 3'b010);
        check_eq({tag, "_pulses"}, {done, timeout, busy}, 3'b000);
        check_eq({tag, "_ad_out"}, ad_out, 8'h00);
        check_eq({tag, "_a_hi"}, a_hi, 8'h00);
        check_eq({tag, "_rdata"}, rdata, 8'h00);
        check_eq({tag, "_ni"}, next_instruction, 8'h00);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req = 1'b0; READY = 1'b1; HOLD = 1'b0;
        cyc_type = 3'd0; addr = 16'h0; wdata = 8'h0; ad_in = 8'h0;
        #1;
        check_reset_state("rst");
        @(negedge phi1);
        reset = 1'b0;
        tick;
        check_eq("rst_idle_busy", busy, 0);

        // Fetch 1234 / 4F, no waits
        full_txn(3'd0, 16'h1234, 8'h00, 0, 8'h4F, 1'b0);
        // Memory write 2000 / A5 with two wait states
        full_txn(3'd2, 16'h2000, 8'hA5, 2, 8'h00, 1'b0);

        // Back-to-back fetch then io read 0080 / 3C
        issue(3'd0, 16'h0456, 8'h00);
        tick;
        check_t1(3'd0, 16'h0456);
        body(3'd0, 8'h00, 1, 8'hC9, 1'b0, 1'b1, 3'd3, 16'h0080, 8'h00);
        check_t1(3'd3, 16'h0080);
        body(3'd3, 8'h00, 0, 8'h3C, 1'b0, 1'b0, 3'd0, 16'h0, 8'h0);
        finish_cycle(1'b0);

        // HOLD raised in T2: cycle completes, then bus released; pending req waits for HOLD to drop
        issue(3'd1, 16'h3344, 8'h00);
        tick;
        check_t1(3'd1, 16'h3344);
        body(3'd1, 8'h00, 1, 8'h77, 1'b1, 1'b0, 3'd0, 16'h0, 8'h0);
        check_eq("hold_hlda", HLDA, 1);
        check_eq("hold_bus_oe", bus_oe, 0);
        check_eq("hold_ad_oe", ad_oe, 0);
        cyc_type = 3'd4; addr = 16'h00F0; wdata = 8'h5C; req = 1'b1;
        #1;
        check_eq("ack_in_hold", req_ack, 0);
        tick;
        check_eq("hold_hlda2", HLDA, 1);
        HOLD = 1'b0;
        #1;
        check_eq("ack_in_hold2", req_ack, 0);
        tick;
        check_eq("release_hlda", HLDA, 0);
        check_eq("release_bus_oe", bus_oe, 1);
        check_eq("pending_ack", req_ack, 1);
        tick;
        check_t1(3'd4, 16'h00F0);
        body(3'd4, 8'h5C, 0, 8'h00, 1'b0, 1'b0, 3'd0, 16'h0, 8'h0);
        finish_cycle(1'b0);

        // HOLD beats req in IDLE
        HOLD = 1'b1; cyc_type = 3'd1; req = 1'b1;
        #1;
        check_eq("hold_beats_req", req_ack, 0);
        tick;
        check_eq("idle_hold_hlda", HLDA, 1);
        req = 1'b0; HOLD = 1'b0;
        tick;
        check_eq("idle_unhold", {HLDA, busy}, 2'b00);

        // READY stuck low: forced close after LIMIT waits, then a clean cycle clears timeout
        full_txn(3'd1, 16'hBEEF, 8'h00, 9, 8'h21, 1'b0);
        full_txn(3'd5, 16'h0000, 8'h00, 0, 8'hFF, 1'b0);

        // Invalid types are never acknowledged
        for (int t = 6; t < 8; t++) begin
            cyc_type = 3'(t); req = 1'b1;
            #1;
            check_eq("invalid_ack", req_ack, 0);
            tick;
            check_eq("invalid_busy", busy, 0);
        end
        req = 1'b0;

        // Asynchronous reset in the middle of a memory write wait state
        READY = 1'b0;
        issue(3'd2, 16'h2000, 8'h5A);
        tick;
        check_t1(3'd2, 16'h2000);
        tick;
        tick;
        check_eq("tw_wrn", WRn, 0);
        #2;
        reset = 1'b1;
        #1;
        check_reset_state("arst");
        #1;
        reset = 1'b0;
        READY = 1'b1;
        exp_rdata = 8'h00; exp_ni = 8'h00; exp_ahi = 8'h00; exp_to = 1'b0;
        tick;
        check_eq("arst_busy", busy, 0);
        check_eq("arst_done", done, 0);

        // Random machine cycles
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  ty;
            logic [15:0] ad;
            logic [7:0]  wd, din;
            int          k;
            bit          hold;
            ty   = 3'($urandom_range(0, 5));
            ad   = 16'($urandom);
            wd   = 8'($urandom);
            din  = 8'($urandom);
            k    = $urandom_range(0, 6);
            hold = ($urandom_range(0, 3) == 0);
            full_txn(ty, ad, wd, k, din, hold);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
